// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver_if: write port and display bus of the 7-segment driver.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface seg7_scan_driver_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [2:0]  mode;
  logic [11:0] digi;
  logic        frame_tick;
  logic        pending;

  modport master (
    output load, value, dp_in, mode,
    input  digi, frame_tick, pending
  );

  modport slave (
    input  load, value, dp_in, mode,
    output digi, frame_tick, pending
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver: double-buffered 4-digit common-anode 7-segment scanner.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  wire logic     clk,
  input  wire logic     reset,
  seg7_scan_driver_if.slave bus
);
  localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_GUARD    = c_CNT_W'(GUARD);
  localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);
  localparam logic [c_FRM_W-1:0] c_FRM_ONE  = c_FRM_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [c_FRM_W-1:0] r_frm;
  logic               r_phase;
  logic [15:0]        r_pend_value, r_act_value;
  logic [3:0]         r_pend_dp, r_act_dp;
  logic [2:0]         r_pend_mode, r_act_mode;
  logic               r_pending;
  logic [11:0]        r_digi;

  logic               w_frame_end;
  logic [3:0]         w_nibble;
  logic               w_upper_zero;
  logic               w_blank;
  logic               w_dark;
  logic [6:0]         w_seg;
  logic [3:0]         w_anodes;
  logic               w_dp_n;
  logic [11:0]        w_digi_next;

  assign w_frame_end    = (r_cnt == c_CNT_LAST) && (r_idx == 2'd3);
  assign bus.frame_tick = w_frame_end;
  assign bus.pending    = r_pending;
  assign bus.digi       = r_digi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else begin
      if (r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (w_frame_end) begin
        if (r_frm == c_FRM_LAST) begin
          r_frm   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frm <= r_frm + c_FRM_ONE;
        end
      end
    end
  end

  // A load on the frame-end cycle bypasses the pending buffer entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_value <= 16'h0000;
      r_pend_dp    <= 4'h0;
      r_pend_mode  <= 3'b000;
      r_act_value  <= 16'h0000;
      r_act_dp     <= 4'h0;
      r_act_mode   <= 3'b000;
      r_pending    <= 1'b0;
    end else begin
      if (bus.load) begin
        r_pend_value <= bus.value;
        r_pend_dp    <= bus.dp_in;
        r_pend_mode  <= bus.mode;
      end
      if (w_frame_end) begin
        if (bus.load) begin
          r_act_value <= bus.value;
          r_act_dp    <= bus.dp_in;
          r_act_mode  <= bus.mode;
        end else if (r_pending) begin
          r_act_value <= r_pend_value;
          r_act_dp    <= r_pend_dp;
          r_act_mode  <= r_pend_mode;
        end
        r_pending <= 1'b0;
      end else if (bus.load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nibble     = r_act_value[3:0];
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd0: begin w_nibble = r_act_value[3:0];   w_upper_zero = 1'b0; end
      2'd1: begin w_nibble = r_act_value[7:4];   w_upper_zero = (r_act_value[15:4]  == 12'h000); end
      2'd2: begin w_nibble = r_act_value[11:8];  w_upper_zero = (r_act_value[15:8]  == 8'h00); end
      default: begin w_nibble = r_act_value[15:12]; w_upper_zero = (r_act_value[15:12] == 4'h0); end
    endcase
  end

  always_comb begin
    w_seg = 7'b1111111;
    case (w_nibble)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      default: w_seg = 7'b0001110;
    endcase
  end

  // A disabled display drives the whole bus idle, segments included.
  assign w_blank     = r_act_mode[1] && (r_idx != 2'd0) && w_upper_zero;
  assign w_dark      = !r_act_mode[0] || (r_cnt < c_GUARD) ||
                       (r_act_mode[2] && r_phase) || w_blank;
  assign w_anodes    = w_dark ? 4'hF : ~(4'b0001 << r_idx);
  assign w_dp_n      = w_blank | ~r_act_dp[r_idx];
  assign w_digi_next = r_act_mode[0] ? {w_anodes, w_dp_n, w_seg} : 12'hFFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digi <= 12'hFFF;
    end else begin
      r_digi <= w_digi_next;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_scan_driver: directed, table-driven bench for seg7_scan_driver.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_driver;
  localparam int SCAN_DIV     = 8;
  localparam int GUARD        = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  typedef struct packed {
    logic [15:0]      value;
    logic [3:0]       dp;
    logic [2:0]       mode;
    logic [11:0]      mask;
    logic [3:0][11:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   k;
  int   n_tests;
  int   n_fail;
  vec_t vecs [7];

  seg7_scan_driver_if bus_if ();

  seg7_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .GUARD       (GUARD),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release: slot position is k%SCAN_DIV, digit (k/SCAN_DIV)%4.
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic wait_state(input int c, input int ix);
    int  budget;
    bit  hit;
    budget = 0;
    hit    = 1'b0;
    while (!hit && budget < 2 * FRAME) begin
      @(negedge clk);
      budget++;
      hit = ((k % SCAN_DIV) == c) && (((k / SCAN_DIV) % 4) == ix);
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_state: timeout waiting for cnt=%0d idx=%0d", c, ix);
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [2:0] m);
    bus_if.load  = 1'b1;
    bus_if.value = v;
    bus_if.dp_in = d;
    bus_if.mode  = m;
    @(negedge clk);
    bus_if.load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         prev;
    int         c;
    int         ix;
    int         tries;
    logic [3:0] exp_an;

    n_tests = 0;
    n_fail  = 0;
    //                value     dp       mode    mask     exp[3]  exp[2]  exp[1]  exp[0]
    vecs[0] = '{16'h12AF, 4'b0001, 3'b001, 12'hFFF, {12'h7F9, 12'hBA4, 12'hD88, 12'hE0E}};
    vecs[1] = '{16'h0070, 4'b1111, 3'b011, 12'hFFF, {12'hFC0, 12'hFC0, 12'hD78, 12'hE40}};
    vecs[2] = '{16'h0000, 4'b0000, 3'b011, 12'hFFF, {12'hFC0, 12'hFC0, 12'hFC0, 12'hEC0}};
    vecs[3] = '{16'h6543, 4'b1010, 3'b001, 12'hFFF, {12'h702, 12'hB92, 12'hD19, 12'hEB0}};
    vecs[4] = '{16'hEDCB, 4'b0000, 3'b011, 12'hFFF, {12'h786, 12'hBA1, 12'hDC6, 12'hE83}};
    vecs[5] = '{16'h0980, 4'b0100, 3'b011, 12'hFFF, {12'hFC0, 12'hB10, 12'hD80, 12'hEC0}};
    vecs[6] = '{16'h1234, 4'b1111, 3'b000, 12'hF00, {12'hF00, 12'hF00, 12'hF00, 12'hF00}};

    reset        = 1'b1;
    bus_if.load  = 1'b0;
    bus_if.value = 16'h0000;
    bus_if.dp_in = 4'h0;
    bus_if.mode  = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_digi", bus_if.digi, 12'hFFF);
    check("reset_pending", {11'b0, bus_if.pending}, 12'd0);
    check("reset_frame_tick", {11'b0, bus_if.frame_tick}, 12'd0);
    reset = 1'b0;

    // Dark for three idle frames; frame_tick only on the last cycle of each frame.
    for (int j = 0; j < 3 * FRAME; j++) begin
      @(negedge clk);
      check("idle_digi", bus_if.digi, 12'hFFF);
      check("idle_frame_tick", {11'b0, bus_if.frame_tick}, {11'b0, (k % FRAME) == FRAME - 1});
    end

    foreach (vecs[v]) begin
      wait_state(5, 0);
      drive_load(vecs[v].value, vecs[v].dp, vecs[v].mode);
      check("vec_pending_set", {11'b0, bus_if.pending}, 12'd1);
      wait_state(SCAN_DIV - 1, 3);
      check("vec_frame_tick", {11'b0, bus_if.frame_tick}, 12'd1);
      check("vec_pending_hold", {11'b0, bus_if.pending}, 12'd1);
      @(negedge clk);
      check("vec_pending_clear", {11'b0, bus_if.pending}, 12'd0);
      for (int i = 0; i < 4; i++) begin
        wait_state(5, i);
        check("vec_digit", bus_if.digi & vecs[v].mask, vecs[v].exp[i] & vecs[v].mask);
      end
    end

    // Guard window: anodes off for the first GUARD cycles of every slot.
    wait_state(5, 0);
    drive_load(16'h12AF, 4'b0001, 3'b001);
    wait_state(SCAN_DIV - 1, 3);
    @(negedge clk);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      prev   = k - 1;
      c      = prev % SCAN_DIV;
      ix     = (prev / SCAN_DIV) % 4;
      exp_an = (c < GUARD) ? 4'hF : (4'hF ^ (4'b0001 << ix));
      check("guard_anode", {8'b0, bus_if.digi[11:8]}, {8'b0, exp_an});
    end

    // Two loads in one frame: the later one wins.
    wait_state(3, 0);
    drive_load(16'h1111, 4'b0000, 3'b001);
    wait_state(2, 1);
    drive_load(16'h2222, 4'b0000, 3'b001);
    check("last_wins_pending", {11'b0, bus_if.pending}, 12'd1);
    wait_state(5, 0);
    check("last_wins_d0", bus_if.digi, 12'hEA4);
    wait_state(5, 3);
    check("last_wins_d3", bus_if.digi, 12'h7A4);

    // Load on the frame-end cycle goes straight to the display.
    wait_state(SCAN_DIV - 1, 3);
    check("bypass_frame_tick", {11'b0, bus_if.frame_tick}, 12'd1);
    drive_load(16'h3333, 4'b0000, 3'b001);
    check("bypass_no_pending", {11'b0, bus_if.pending}, 12'd0);
    wait_state(5, 0);
    check("bypass_d0", bus_if.digi, 12'hEB0);
    check("bypass_pending_low", {11'b0, bus_if.pending}, 12'd0);

    // Blink: phase of frame n is (n/BLINK_FRAMES)%2 counted from reset release.
    wait_state(5, 0);
    drive_load(16'h8888, 4'b0000, 3'b101);
    wait_state(SCAN_DIV - 1, 3);
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      wait_state(5, 0);
      check("blink_d0", bus_if.digi,
            (((k / FRAME) / BLINK_FRAMES) % 2 == 1) ? 12'hF80 : 12'hE80);
    end
    tries = 0;
    do begin
      wait_state(5, 0);
      tries++;
    end while (((k / FRAME) % 4) != 2 && tries < 8);
    check("blink_find_frame", {11'b0, ((k / FRAME) % 4) == 2}, 12'd1);
    drive_load(16'h8888, 4'b0000, 3'b001);
    check("blink_clear_not_yet", bus_if.digi, 12'hF80);
    wait_state(5, 0);
    check("blink_cleared", bus_if.digi, 12'hE80);

    // Asynchronous reset mid-slot with a write pending.
    wait_state(5, 0);
    drive_load(16'hABCD, 4'hF, 3'b001);
    check("pre_reset_pending", {11'b0, bus_if.pending}, 12'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_digi", bus_if.digi, 12'hFFF);
    check("async_reset_pending", {11'b0, bus_if.pending}, 12'd0);
    check("async_reset_frame_tick", {11'b0, bus_if.frame_tick}, 12'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_state(5, 0);
    wait_state(5, 0);
    check("post_reset_dark", bus_if.digi, 12'hFFF);
    check("post_reset_pending", {11'b0, bus_if.pending}, 12'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
